// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the MIPS32 memory controller's level-held request into a single
// transaction on either on-chip BRAM (fixed 1-cycle latency) or an external req/ack bus with timeout.
module dmem_bridge #(
  parameter logic [31:0] BRAM_BASE = 32'h0000_0000,
  parameter int          BRAM_AW   = 14,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        Address,
  input  logic [31:0]        MWriteData,
  input  logic [3:0]         WriteEnable,
  input  logic               ReadEnable,
  output logic [31:0]        MReadData,
  output logic               DataMem_Ready,
  output logic               bram_en,
  output logic [3:0]         bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [31:0]        bram_wdata,
  input  logic [31:0]        bram_rdata,
  output logic               ext_req,
  output logic [3:0]         ext_we,
  output logic [29:0]        ext_addr,
  output logic [31:0]        ext_wdata,
  input  logic [31:0]        ext_rdata,
  input  logic               ext_ack,
  output logic               bus_error
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, B_RESP, E_REQ, E_RESP} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          err_flag;
  logic [31:0]   rdata_reg;
  logic          req, hit, timeout_hit;
  logic          unused_addr_lsbs;

  assign req         = ReadEnable | (|WriteEnable);
  assign hit         = Address[31:BRAM_AW+2] == BRAM_BASE[31:BRAM_AW+2];
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign bram_addr   = Address[BRAM_AW+1:2];
  assign bram_wdata  = MWriteData;
  // Byte offset is ignored: the controller has already trapped misaligned accesses.
  assign unused_addr_lsbs = ^Address[1:0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Response states return to IDLE unconditionally, so the still-held request
  // in a Ready cycle can never launch a second transaction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = hit ? B_RESP : E_REQ;
      B_RESP:  state_nxt = IDLE;
      E_REQ:   if (ext_ack || timeout_hit) state_nxt = E_RESP;
      E_RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bram_en       = (state == IDLE) && req && hit && !reset;
    bram_we       = bram_en ? WriteEnable : 4'b0000;
    DataMem_Ready = !reset && ((state == B_RESP) || (state == E_RESP));
    bus_error     = !reset && (state == E_RESP) && err_flag;
    MReadData     = (state == B_RESP) ? bram_rdata : rdata_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_req   <= 1'b0;
      ext_we    <= 4'b0000;
      ext_addr  <= '0;
      ext_wdata <= '0;
      rdata_reg <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req && !hit) begin
          ext_addr  <= Address[31:2];
          ext_we    <= WriteEnable;
          ext_wdata <= MWriteData;
          ext_req   <= 1'b1;
          cnt       <= '0;
        end
        E_REQ: begin
          cnt <= cnt + 1'b1;
          // An ack in the final timeout cycle still completes normally.
          if (ext_ack) begin
            rdata_reg <= ext_rdata;
            ext_req   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_reg <= ERR_DATA;
            ext_req   <= 1'b0;
            err_flag  <= 1'b1;
          end
        end
        E_RESP:  err_flag <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed vector table, reset corner sequences, and random accesses
// checked against a word/byte-level memory model and the external-bus latency rules.
module tb_dmem_bridge;
  localparam int AW = 10;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   Address, MWriteData, MReadData;
  logic [3:0]    WriteEnable;
  logic          ReadEnable, DataMem_Ready;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata, bram_rdata;
  logic          ext_req, ext_ack, bus_error;
  logic [3:0]    ext_we;
  logic [29:0]   ext_addr;
  logic [31:0]   ext_wdata, ext_rdata;

  always #5 clock = ~clock;

  dmem_bridge #(.BRAM_BASE(32'h0), .BRAM_AW(AW), .TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clock(clock), .reset(reset), .Address(Address), .MWriteData(MWriteData),
    .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .MReadData(MReadData),
    .DataMem_Ready(DataMem_Ready), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack), .bus_error(bus_error));

  // BRAM device: byte-writable, read data one cycle after enable
  logic [31:0] bmem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) bmem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
      bram_rdata <= bmem[bram_addr];
    end
  end

  // Reference model: contents and known-byte mask per BRAM word
  logic [31:0] ref_mem   [int];
  logic [3:0]  ref_known [int];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void ref_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] we);
    int w;
    w = int'(addr[AW+1:2]);
    if (!ref_mem.exists(w)) begin ref_mem[w] = 32'h0; ref_known[w] = 4'h0; end
    for (int b = 0; b < 4; b++)
      if (we[b]) begin ref_mem[w][8*b +: 8] = wd[8*b +: 8]; ref_known[w][b] = 1'b1; end
  endfunction

  // Observations of one access
  int          o_rdy, o_nrdy, o_nen, o_nreq;
  logic        o_err;
  logic [31:0] o_rd, o_ewd;
  logic [29:0] o_eaddr;
  logic [3:0]  o_ewe;

  // Behaves like the controller: holds the request through the Ready cycle, then drops it.
  // Called and returns at posedge+1 (drive time).
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] we,
                            input logic re, input int ack_at, input logic [31:0] ack_data);
    int c;
    bit done;
    o_rdy = -1; o_nrdy = 0; o_nen = 0; o_nreq = 0; o_err = 1'b0;
    o_rd = '0; o_ewd = '0; o_eaddr = '0; o_ewe = '0;
    Address = addr; MWriteData = wd; WriteEnable = we; ReadEnable = re;
    c = 0; done = 0;
    while (!done) begin
      ext_ack   = (c == ack_at);
      ext_rdata = (c == ack_at) ? ack_data : 32'h0;
      @(negedge clock);
      if (bram_en) o_nen++;
      if (ext_req) begin
        if (o_nreq == 0) begin o_eaddr = ext_addr; o_ewe = ext_we; o_ewd = ext_wdata; end
        o_nreq++;
      end
      if (DataMem_Ready) begin
        o_nrdy++;
        if (o_rdy < 0) begin o_rdy = c; o_rd = MReadData; o_err = bus_error; end
      end
      @(posedge clock); #1;
      c++;
      if (o_rdy >= 0 && c == o_rdy + 1) begin ReadEnable = 1'b0; WriteEnable = 4'b0; end
      if (o_rdy >= 0 && c > o_rdy + 2 && c > ack_at + 1) done = 1;
      if (c >= 64) done = 1;
    end
    ReadEnable = 1'b0; WriteEnable = 4'b0; ext_ack = 1'b0; ext_rdata = 32'h0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr, wd;
    logic [3:0]  we;
    logic        re;
    int          ack_at;
    logic [31:0] ack_data;
    int          exp_rdy;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_nen, exp_nreq;
    logic [29:0] exp_eaddr;
    logic [3:0]  exp_ewe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] exp_rd, mask, addr, wd, ad;
    logic [3:0]  we;
    logic        re, exp_err;
    int          ack_at, exp_rdy, exp_nreq, w;
    bit          ext, bad;

    vecs[0] = '{"bwr_full",  32'h0000_0040, 32'h1234_5678, 4'b1111, 1'b0, -1, 32'h0, 1, 1'b0, 1'b0, 32'h0, 1, 0, 30'h0, 4'h0};
    vecs[1] = '{"bwr_byte",  32'h0000_0040, 32'hAAAA_AAAA, 4'b0100, 1'b0, -1, 32'h0, 1, 1'b0, 1'b0, 32'h0, 1, 0, 30'h0, 4'h0};
    vecs[2] = '{"brd",       32'h0000_0040, 32'h0,         4'b0000, 1'b1, -1, 32'h0, 1, 1'b0, 1'b1, 32'h12AA_5678, 1, 0, 30'h0, 4'h0};
    vecs[3] = '{"ext_rd",    32'h8000_0010, 32'h0,         4'b0000, 1'b1, 5, 32'hCAFE_F00D, 6, 1'b0, 1'b1, 32'hCAFE_F00D, 0, 5, 30'h2000_0004, 4'h0};
    vecs[4] = '{"ext_tmo",   32'h8000_0020, 32'h1122_3344, 4'b1111, 1'b0, 12, 32'h7777_7777, 9, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, 8, 30'h2000_0008, 4'hF};
    vecs[5] = '{"ext_coinc", 32'h8000_0030, 32'h0,         4'b0000, 1'b1, 8, 32'h5555_AAAA, 9, 1'b0, 1'b1, 32'h5555_AAAA, 0, 8, 30'h2000_000C, 4'h0};
    vecs[6] = '{"b_rw_prio", 32'h0000_0044, 32'h0BAD_BEEF, 4'b1111, 1'b1, -1, 32'h0, 1, 1'b0, 1'b0, 32'h0, 1, 0, 30'h0, 4'h0};
    vecs[7] = '{"brd2",      32'h0000_0044, 32'h0,         4'b0000, 1'b1, -1, 32'h0, 1, 1'b0, 1'b1, 32'h0BAD_BEEF, 1, 0, 30'h0, 4'h0};

    // Reset with a hitting write pending: BRAM must stay disabled
    reset = 1'b1; Address = 32'h40; MWriteData = 32'hFFFF_FFFF; WriteEnable = 4'b1111; ReadEnable = 1'b0;
    ext_ack = 1'b0; ext_rdata = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_bram_en", 32'(bram_en), 32'h0);
    chk("rst_bram_we", 32'(bram_we), 32'h0);
    chk("rst_ready",   32'(DataMem_Ready), 32'h0);
    chk("rst_ext_req", 32'(ext_req), 32'h0);
    @(posedge clock); #1;
    WriteEnable = 4'b0; reset = 1'b0;
    @(negedge clock);
    chk("rst_ext_addr",  32'(ext_addr), 32'h0);
    chk("rst_ext_we",    32'(ext_we), 32'h0);
    chk("rst_ext_wdata", ext_wdata, 32'h0);
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    chk("rst_rdata",     MReadData, 32'h0);
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      run_access(vecs[i].addr, vecs[i].wd, vecs[i].we, vecs[i].re, vecs[i].ack_at, vecs[i].ack_data);
      if (vecs[i].exp_nen != 0 && vecs[i].we != 0) ref_write(vecs[i].addr, vecs[i].wd, vecs[i].we);
      chk({vecs[i].name, ".rdy"},  32'(o_rdy),  32'(vecs[i].exp_rdy));
      chk({vecs[i].name, ".nrdy"}, 32'(o_nrdy), 32'd1);
      chk({vecs[i].name, ".err"},  32'(o_err),  32'(vecs[i].exp_err));
      chk({vecs[i].name, ".nen"},  32'(o_nen),  32'(vecs[i].exp_nen));
      chk({vecs[i].name, ".nreq"}, 32'(o_nreq), 32'(vecs[i].exp_nreq));
      if (vecs[i].chk_rd) chk({vecs[i].name, ".rd"}, o_rd, vecs[i].exp_rd);
      if (vecs[i].exp_nreq > 0) begin
        chk({vecs[i].name, ".eaddr"}, 32'(o_eaddr), 32'(vecs[i].exp_eaddr));
        chk({vecs[i].name, ".ewe"},   32'(o_ewe),   32'(vecs[i].exp_ewe));
      end
    end

    // Reset during cycle 3 of an external read: aborted, no Ready
    Address = 32'h8000_0040; ReadEnable = 1'b1; WriteEnable = 4'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("abort.ready_c3", 32'(DataMem_Ready), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; ReadEnable = 1'b0;
    @(negedge clock);
    chk("abort.ext_req", 32'(ext_req), 32'h0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (DataMem_Ready || ext_req || bus_error) bad = 1;
    end
    chk("abort.quiet", 32'(bad), 32'h0);
    @(posedge clock); #1;
    run_access(32'h0000_0040, 32'h0, 4'b0000, 1'b1, -1, 32'h0);
    chk("abort.b_rdy", 32'(o_rdy), 32'd1);
    chk("abort.b_rd",  o_rd, ref_mem[16]);

    // Random accesses against the model
    for (int n = 0; n < 60; n++) begin
      ext = ($urandom_range(0, 2) == 0);
      we  = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      re  = (we == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wd  = $urandom;
      ack_at = $urandom_range(1, 11);
      ad  = $urandom;
      if (ext) addr = 32'h8000_0000 | (ad & 32'h0FFF_FFFF);
      else     addr = {20'h0, 5'h0, 5'($urandom_range(0, 31)), ad[1:0]};
      run_access(addr, wd, we, re, ext ? ack_at : -1, ad);
      if (ext) begin
        exp_rdy  = (ack_at <= TO) ? ack_at + 1 : TO + 1;
        exp_err  = (ack_at > TO);
        exp_nreq = (ack_at <= TO) ? ack_at : TO;
        exp_rd   = (ack_at <= TO) ? ad : 32'hDEAD_BEEF;
        chk("rnd.ext_rd",    o_rd, exp_rd);
        chk("rnd.ext_nreq",  32'(o_nreq), 32'(exp_nreq));
        chk("rnd.ext_eaddr", 32'(o_eaddr), 32'(addr[31:2]));
        chk("rnd.ext_ewe",   32'(o_ewe), 32'(we));
        if (we != 0) chk("rnd.ext_ewd", o_ewd, wd);
      end else begin
        exp_rdy = 1; exp_err = 1'b0;
        w = int'(addr[AW+1:2]);
        if (we == 0 && ref_mem.exists(w)) begin
          mask = {{8{ref_known[w][3]}}, {8{ref_known[w][2]}}, {8{ref_known[w][1]}}, {8{ref_known[w][0]}}};
          if (mask != 0) chk("rnd.b_rd", o_rd & mask, ref_mem[w] & mask);
        end
        if (we != 0) ref_write(addr, wd, we);
      end
      chk("rnd.rdy",  32'(o_rdy),  32'(exp_rdy));
      chk("rnd.nrdy", 32'(o_nrdy), 32'd1);
      chk("rnd.err",  32'(o_err),  32'(exp_err));
      chk("rnd.nen",  32'(o_nen),  ext ? 32'd0 : 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
